tile_dispatch_router: RTL and testbench
=======================================

// Module: tile_dispatch_router
// PURPOSE
//  Downstream stage of the workload allocator. Buffers the tile pixel stream read from the tile BRAM, one tile per bank.
//  Holds each tile until the allocator's per-tile route decision arrives.
//  Then replays the whole tile to either the CNN path or the lightweight (lite) path over a valid/ready stream.
//  Ping-pong banks let tile N+1 fill while tile N drains.
// PARAMETERS
//  DATA_W       8    pixel width
//  TILE_WIDTH   16   tile columns
//  TILE_HEIGHT  16   tile rows; TILE_PIX = TILE_WIDTH*TILE_HEIGHT = 256
//  DEC_DEPTH    2    decision FIFO depth (power of 2)
// PORTS
//  iClk            in   1       clock, all logic rising edge
//  iRst            in   1       asynchronous reset, active low
//  iData           in   DATA_W  pixel from tile BRAM
//  iValid          in   1       iData valid
//  oReady          out  1       free bank available; pixel accepted when iValid&&oReady
//  iRouteToCnn     in   1       route decision, 1=CNN, 0=lite
//  iDecisionValid  in   1       one-cycle decision strobe
//  oCnnData        out  DATA_W  CNN stream data
//  oCnnValid       out  1       CNN stream valid
//  iCnnReady       in   1       CNN stream ready
//  oLiteData       out  DATA_W  lite stream data
//  oLiteValid      out  1       lite stream valid
//  iLiteReady      in   1       lite stream ready
//  oLast           out  1       marks last pixel of tile on whichever stream is valid
//  oBusy           out  1       any bank full or draining
//  oDecErr         out  1       sticky: decision dropped, FIFO full
// BEHAVIOUR
//  Reset (async, iRst=0): all outputs 0 except oReady=1; banks empty; wr_bank=0, rd_bank=0; pixel cnts 0; dec FIFO empty.
//  Reset mid-tile discards all buffered pixels and decisions; no partial tile is ever emitted.
//  Write side:
//   - accepted pixel -> bank[wr_bank][wr_cnt]; wr_cnt++.
//   - at wr_cnt==TILE_PIX-1: bank marked full, wr_cnt=0, wr_bank toggles.
//   - oReady = !full[wr_bank]; both banks full -> oReady=0.
//  Decision FIFO:
//   - push on iDecisionValid; pop when a tile drain completes.
//   - push while full: drop, set oDecErr (cleared only by reset).
//   - push and pop in same cycle when full: accepted, no error.
//  Read FSM states IDLE, LOAD, DRAIN, FLUSH:
//   - IDLE: full[rd_bank] && dec FIFO non-empty -> latch route = FIFO head -> LOAD.
//   - LOAD: issue RAM read addr 0 (1-cycle RAM latency) -> DRAIN.
//   - DRAIN: output register drives selected stream; valid held, data stable until ready.
//     Handshake fires when valid&&ready on selected stream; unselected stream valid stays 0.
//     RAM read of next address prefetched on each handshake, so throughput is 1 pixel/cycle with ready held high.
//     oLast=1 with pixel TILE_PIX-1; its handshake -> FLUSH.
//   - FLUSH: clear full[rd_bank], toggle rd_bank, pop decision -> IDLE.
//  Latency: first valid 2 cycles after both tile-full and decision present (IDLE->LOAD->DRAIN).
//  Decision arriving before its tile completes is legal. Ordering is strictly FIFO: k-th decision binds to k-th tile.
//  Counters wrap only at TILE_PIX-1. Address width = clog2(TILE_PIX)+1 (bank bit MSB).
//  Full flag set (write side) and clear (FLUSH) target different banks; same cycle is legal.
//  A bank becomes writable the cycle after FLUSH.
// STRUCTURE
//  Shared header tile_router_defs.vh: FSM state encodings, TILE_PIX, clog2 function.
//   Same TILE_WIDTH/HEIGHT macros also used by Bram_interface config.
//  Sub-module tile_pingpong_ram: simple dual-port RAM, depth 2*TILE_PIX, 1 write port, 1 registered read port.
//  FSM, FIFO, counters stay in top.
// TESTING
//  1 tile ramp 0..255, then decision=1, iCnnReady=1 -> oCnnValid 256 cycles, data 0..255, oLast on 255; oLiteValid never 1.
//  Decision=0 sent before tile start -> tile on lite stream; first oLiteValid 2 cycles after 256th pixel accepted.
//  3 tiles back-to-back, no decisions -> oReady=0 after 512 pixels; decisions 1,0 -> tile0 CNN, tile1 lite; 3rd tile accepted.
//  iCnnReady toggled 1/0 each cycle during drain -> data held stable while not ready; 256 unique pixels, no loss or duplication.
//  3 decision strobes with no tiles -> oDecErr=1 after 3rd; stays 1 until iRst=0.
//  iRst=0 at pixel 100 of a drain -> all valids 0 immediately; after release oReady=1, next tile output starts at pixel 0.

Source files
------------

// File: rtl/tile_dispatch_router_pkg.sv
// Shared definitions for the tile dispatch router: default geometry and
// the read-side FSM state encoding.
package tile_dispatch_router_pkg;

    localparam int DEF_DATA_W      = 8;
    localparam int DEF_TILE_WIDTH  = 16;
    localparam int DEF_TILE_HEIGHT = 16;
    localparam int DEF_DEC_DEPTH   = 2;

    typedef enum logic [1:0] {
        RD_IDLE  = 2'd0,
        RD_LOAD  = 2'd1,
        RD_DRAIN = 2'd2,
        RD_FLUSH = 2'd3
    } rdState_e;

endpackage

// File: rtl/tile_pingpong_ram.sv
// Simple dual-port tile buffer: one write port, one registered read port.
// The bank select is the address MSB; the read register only updates when
// a read is issued, so it doubles as the stream output register.
module tile_pingpong_ram #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 9
) (
    input  logic              iClk,
    input  logic              iWrEn,
    input  logic [ADDR_W-1:0] iWrAddr,
    input  logic [DATA_W-1:0] iWrData,
    input  logic              iRdEn,
    input  logic [ADDR_W-1:0] iRdAddr,
    output logic [DATA_W-1:0] oRdData
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // Pixel store
    always_ff @(posedge iClk) begin
        if (iWrEn) mem[iWrAddr] <= iWrData;
    end

    // Registered read, held between reads
    always_ff @(posedge iClk) begin
        if (iRdEn) oRdData <= mem[iRdAddr];
    end

endmodule

// File: rtl/tile_dispatch_router.sv
// Tile dispatch router: buffers tiles in ping-pong banks and replays each
// full tile to the CNN or lite stream once its route decision is known.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// RD_IDLE  | wait for full[rdBank] and a queued decision, latch route
// RD_LOAD  | issue RAM read of pixel 0 (one-cycle read latency)
// RD_DRAIN | present pixels on the selected stream, prefetch on handshake
// RD_FLUSH | free the bank, toggle rdBank, pop the decision
module tile_dispatch_router
    import tile_dispatch_router_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int TILE_WIDTH  = DEF_TILE_WIDTH,
    parameter int TILE_HEIGHT = DEF_TILE_HEIGHT,
    parameter int DEC_DEPTH   = DEF_DEC_DEPTH
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic [DATA_W-1:0] iData,
    input  logic              iValid,
    output logic              oReady,
    input  logic              iRouteToCnn,
    input  logic              iDecisionValid,
    output logic [DATA_W-1:0] oCnnData,
    output logic              oCnnValid,
    input  logic              iCnnReady,
    output logic [DATA_W-1:0] oLiteData,
    output logic              oLiteValid,
    input  logic              iLiteReady,
    output logic              oLast,
    output logic              oBusy,
    output logic              oDecErr
);

    localparam int TILE_PIX  = TILE_WIDTH * TILE_HEIGHT;
    localparam int PIX_W     = $clog2(TILE_PIX);
    localparam int ADDR_W    = PIX_W + 1;
    localparam int DEC_PTR_W = (DEC_DEPTH > 1) ? $clog2(DEC_DEPTH) : 1;
    localparam int DEC_CNT_W = $clog2(DEC_DEPTH + 1);
    localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(TILE_PIX - 1);

    rdState_e              state, stateNext;
    logic [1:0]            full;
    logic                  wrBank, rdBank;
    logic [PIX_W-1:0]      wrCnt, rdCnt, rdCntNext;
    logic                  route;
    logic                  pixAccept;
    logic                  draining, selReady, handshake;

    logic [DEC_DEPTH-1:0]  decMem;
    logic [DEC_PTR_W-1:0]  decWrPtr, decRdPtr;
    logic [DEC_CNT_W-1:0]  decCount;
    logic                  decFull, decEmpty, decPush, decPop;
    logic                  decErr;

    logic                  ramRdEn;
    logic [ADDR_W-1:0]     ramRdAddr;
    logic [DATA_W-1:0]     ramRdData;

    assign oReady    = !full[wrBank];
    assign pixAccept = iValid && oReady;

    assign draining  = (state == RD_DRAIN);
    assign selReady  = route ? iCnnReady : iLiteReady;
    assign handshake = draining && selReady;
    assign rdCntNext = rdCnt + 1'b1;

    assign decFull  = (decCount == DEC_CNT_W'(DEC_DEPTH));
    assign decEmpty = (decCount == '0);
    assign decPop   = (state == RD_FLUSH);
    // A push into a full FIFO is still taken when the head leaves the same cycle
    assign decPush  = iDecisionValid && (!decFull || decPop);

    assign oCnnValid  = draining && route;
    assign oLiteValid = draining && !route;
    assign oCnnData   = oCnnValid  ? ramRdData : '0;
    assign oLiteData  = oLiteValid ? ramRdData : '0;
    assign oLast      = draining && (rdCnt == LAST_PIX);
    assign oBusy      = |full;
    assign oDecErr    = decErr;

    tile_pingpong_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) uRam (
        .iClk    (iClk),
        .iWrEn   (pixAccept),
        .iWrAddr ({wrBank, wrCnt}),
        .iWrData (iData),
        .iRdEn   (ramRdEn),
        .iRdAddr (ramRdAddr),
        .oRdData (ramRdData)
    );

    // Write pointer: fill the current bank, move to the other bank after the last pixel
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            wrBank <= 1'b0;
            wrCnt  <= '0;
        end else if (pixAccept) begin
            if (wrCnt == LAST_PIX) begin
                wrCnt  <= '0;
                wrBank <= ~wrBank;
            end else begin
                wrCnt <= wrCnt + 1'b1;
            end
        end
    end

    // Bank full flags: set by the writer, cleared by the reader (always different banks)
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            full <= '0;
        end else begin
            if (pixAccept && (wrCnt == LAST_PIX)) full[wrBank] <= 1'b1;
            if (state == RD_FLUSH)               full[rdBank] <= 1'b0;
        end
    end

    // Decision FIFO with sticky overflow flag
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            decMem   <= '0;
            decWrPtr <= '0;
            decRdPtr <= '0;
            decCount <= '0;
            decErr   <= 1'b0;
        end else begin
            if (decPush) begin
                decMem[decWrPtr] <= iRouteToCnn;
                decWrPtr         <= decWrPtr + 1'b1;
            end
            if (decPop) decRdPtr <= decRdPtr + 1'b1;
            if (decPush && !decPop)      decCount <= decCount + 1'b1;
            else if (!decPush && decPop) decCount <= decCount - 1'b1;
            if (iDecisionValid && !decPush) decErr <= 1'b1;
        end
    end

    // Read FSM state register
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) state <= RD_IDLE;
        else       state <= stateNext;
    end

    // Read FSM next state and RAM read requests
    always_comb begin
        stateNext = state;
        ramRdEn   = 1'b0;
        ramRdAddr = {rdBank, {PIX_W{1'b0}}};
        case (state)
            RD_IDLE: begin
                if (full[rdBank] && !decEmpty) stateNext = RD_LOAD;
            end
            RD_LOAD: begin
                ramRdEn   = 1'b1;
                stateNext = RD_DRAIN;
            end
            RD_DRAIN: begin
                if (handshake) begin
                    if (rdCnt == LAST_PIX) begin
                        stateNext = RD_FLUSH;
                    end else begin
                        ramRdEn   = 1'b1;
                        ramRdAddr = {rdBank, rdCntNext};
                    end
                end
            end
            RD_FLUSH: begin
                stateNext = RD_IDLE;
            end
            default: begin
                stateNext = RD_IDLE;
            end
        endcase
    end

    // Read-side datapath: route latch, pixel index of the presented pixel, read bank
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            route  <= 1'b0;
            rdBank <= 1'b0;
            rdCnt  <= '0;
        end else begin
            case (state)
                RD_IDLE:  if (stateNext == RD_LOAD) route <= decMem[decRdPtr];
                RD_LOAD:  rdCnt <= '0;
                RD_DRAIN: if (handshake && (rdCnt != LAST_PIX)) rdCnt <= rdCntNext;
                RD_FLUSH: rdBank <= ~rdBank;
                default:  ;
            endcase
        end
    end

endmodule

// File: tb/tb_tile_dispatch_router.sv
// Bench for tile_dispatch_router: a queue-based model of buffered tiles and
// pending decisions is checked against the DUT every cycle, with directed
// scenarios adding literal expectations on latency, counts and flags.
module tb_tile_dispatch_router;

    localparam int TILE_PIX = 256;

    logic       iClk = 1'b0;
    logic       iRst;
    logic [7:0] iData;
    logic       iValid;
    logic       oReady;
    logic       iRouteToCnn;
    logic       iDecisionValid;
    logic [7:0] oCnnData;
    logic       oCnnValid;
    logic       iCnnReady;
    logic [7:0] oLiteData;
    logic       oLiteValid;
    logic       iLiteReady;
    logic       oLast;
    logic       oBusy;
    logic       oDecErr;

    tile_dispatch_router dut (
        .iClk           (iClk),
        .iRst           (iRst),
        .iData          (iData),
        .iValid         (iValid),
        .oReady         (oReady),
        .iRouteToCnn    (iRouteToCnn),
        .iDecisionValid (iDecisionValid),
        .oCnnData       (oCnnData),
        .oCnnValid      (oCnnValid),
        .iCnnReady      (iCnnReady),
        .oLiteData      (oLiteData),
        .oLiteValid     (oLiteValid),
        .iLiteReady     (iLiteReady),
        .oLast          (oLast),
        .oBusy          (oBusy),
        .oDecErr        (oDecErr)
    );

    always #5 iClk = ~iClk;

    int cyc = 0;
    always @(posedge iClk) cyc <= cyc + 1;

    // ---------------- model state (written only by the monitor) ----------------
    logic [7:0] pixQ[$];      // pixels of completed tiles, oldest tile first
    logic [7:0] curTile[$];   // tile currently being written
    bit         decQ[$];      // accepted decisions, head is the tile being drained
    int         tileCnt, outIdx, accCount, tilesFilled, tilesDone;
    int         hsCnn, hsLite, cnnValidCycles, liteValidCycles;
    int         riseCyc, riseData;
    bit         flushPending, flushNow, expErr;
    bit         prevValid, prevHs, anyV, possible, expCnn, hs, acceptOk;
    logic [7:0] outData, prevData;
    int         monErrors = 0, monChecks = 0;
    int         drvErrors = 0, drvChecks = 0;

    task automatic monCheck(input string name, input longint act, input longint exp);
        monChecks++;
        if (act != exp) begin
            monErrors++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic drvCheck(input string name, input longint act, input longint exp);
        drvChecks++;
        if (act != exp) begin
            drvErrors++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // Compare process: sampled mid-cycle, away from the active edge
    always @(negedge iClk) begin
        if (!iRst) begin
            pixQ.delete(); curTile.delete(); decQ.delete();
            tileCnt = 0; outIdx = 0; accCount = 0; tilesFilled = 0; tilesDone = 0;
            hsCnn = 0; hsLite = 0; cnnValidCycles = 0; liteValidCycles = 0;
            flushPending = 0; expErr = 0; prevValid = 0; prevHs = 0; prevData = '0;
            monCheck("rst_ready", oReady, 1);
            monCheck("rst_cnn_valid", oCnnValid, 0);
            monCheck("rst_lite_valid", oLiteValid, 0);
            monCheck("rst_last", oLast, 0);
            monCheck("rst_busy", oBusy, 0);
            monCheck("rst_decerr", oDecErr, 0);
        end else begin
            flushNow     = flushPending;
            flushPending = 0;
            acceptOk     = (tileCnt < 2);
            monCheck("ready", oReady, acceptOk);
            monCheck("busy", oBusy, tileCnt != 0);
            monCheck("dec_err", oDecErr, expErr);

            anyV     = oCnnValid || oLiteValid;
            possible = (tileCnt != 0) && (decQ.size() != 0) && !flushNow;
            outData  = oCnnValid ? oCnnData : oLiteData;
            hs       = 0;
            monCheck("both_valid", oCnnValid && oLiteValid, 0);
            monCheck("valid_without_tile_or_decision", anyV && !possible, 0);
            if (anyV && possible) begin
                expCnn = decQ[0];
                monCheck("stream_select_cnn", oCnnValid, expCnn);
                monCheck("pixel_data", outData, pixQ[outIdx]);
                monCheck("last_flag", oLast, outIdx == TILE_PIX - 1);
                hs = expCnn ? iCnnReady : iLiteReady;
            end else if (!anyV) begin
                monCheck("last_without_valid", oLast, 0);
            end
            if (prevValid && !prevHs) begin
                monCheck("valid_held", anyV, 1);
                if (anyV) monCheck("data_stable", outData, prevData);
            end
            if (anyV && !prevValid) begin
                riseCyc  = cyc;
                riseData = outData;
            end

            if (iValid && acceptOk) begin
                curTile.push_back(iData);
                accCount++;
                if (curTile.size() == TILE_PIX) begin
                    foreach (curTile[i]) pixQ.push_back(curTile[i]);
                    curTile.delete();
                    tileCnt++;
                    tilesFilled++;
                end
            end

            if (flushNow) begin
                repeat (TILE_PIX) void'(pixQ.pop_front());
                void'(decQ.pop_front());
                tileCnt--;
                tilesDone++;
            end
            if (iDecisionValid) begin
                if (decQ.size() < 2) decQ.push_back(iRouteToCnn);
                else                 expErr = 1;
            end

            if (hs) begin
                if (expCnn) hsCnn++;
                else        hsLite++;
                if (outIdx == TILE_PIX - 1) begin
                    outIdx       = 0;
                    flushPending = 1;
                end else begin
                    outIdx++;
                end
            end
            if (oCnnValid)  cnnValidCycles++;
            if (oLiteValid) liteValidCycles++;
            prevValid = anyV;
            prevHs    = hs;
            prevData  = outData;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    task automatic applyReset();
        iRst           = 1'b0;
        iValid         = 1'b0;
        iDecisionValid = 1'b0;
        repeat (3) tick();
        iRst = 1'b1;
        tick();
    endtask

    task automatic decide(input bit r, output int dcyc);
        iRouteToCnn    = r;
        iDecisionValid = 1'b1;
        dcyc           = cyc;
        tick();
        iDecisionValid = 1'b0;
    endtask

    task automatic sendTile(input int base, input int stride, output int lastCyc);
        int waitCnt;
        lastCyc = -1;
        for (int i = 0; i < TILE_PIX; i++) begin
            iData   = 8'(base + stride * i);
            iValid  = 1'b1;
            waitCnt = 0;
            while (!oReady && waitCnt < 3000) begin
                tick();
                waitCnt++;
            end
            if (!oReady) begin
                drvCheck("ready_timeout", oReady, 1);
                iValid = 1'b0;
                return;
            end
            lastCyc = cyc;
            tick();
        end
        iValid = 1'b0;
    endtask

    task automatic waitHs(input int target, input int bound);
        int n = 0;
        while ((hsCnn + hsLite) < target && n < bound) begin
            tick();
            n++;
        end
        drvCheck("handshake_total", hsCnn + hsLite, target);
    endtask

    initial begin
        int dcyc, lcyc, n;
        iRst = 1'b0; iValid = 1'b0; iData = '0; iRouteToCnn = 1'b0;
        iDecisionValid = 1'b0; iCnnReady = 1'b1; iLiteReady = 1'b1;
        #1;
        drvCheck("reset_ready", oReady, 1);
        drvCheck("reset_busy", oBusy, 0);
        drvCheck("reset_cnn_valid", oCnnValid, 0);

        // Ramp tile, decision afterwards, CNN ready held high
        applyReset();
        sendTile(0, 1, lcyc);
        repeat (2) tick();
        drvCheck("t1_busy_while_held", oBusy, 1);
        decide(1'b1, dcyc);
        waitHs(TILE_PIX, 1000);
        repeat (3) tick();
        drvCheck("t1_latency_from_decision", riseCyc - dcyc, 3);
        drvCheck("t1_first_pixel", riseData, 0);
        drvCheck("t1_cnn_valid_cycles", cnnValidCycles, 256);
        drvCheck("t1_lite_valid_cycles", liteValidCycles, 0);
        drvCheck("t1_busy_after_drain", oBusy, 0);

        // Lite decision before the tile arrives
        applyReset();
        decide(1'b0, dcyc);
        sendTile(8'hA5, 3, lcyc);
        waitHs(TILE_PIX, 1000);
        drvCheck("t2_latency_from_last_pixel", riseCyc - lcyc, 3);
        drvCheck("t2_first_pixel", riseData, 8'hA5);
        drvCheck("t2_cnn_valid_cycles", cnnValidCycles, 0);

        // Three tiles back to back with no decisions, then CNN, lite
        applyReset();
        sendTile(0, 1, lcyc);
        sendTile(3, 5, lcyc);
        iData  = 8'd100;
        iValid = 1'b1;
        repeat (3) tick();
        drvCheck("t3_ready_low_after_512", oReady, 0);
        drvCheck("t3_accepted_512", accCount, 512);
        decide(1'b1, dcyc);
        decide(1'b0, dcyc);
        sendTile(100, 3, lcyc);
        waitHs(2 * TILE_PIX, 2000);
        drvCheck("t3_cnn_pixels", hsCnn, 256);
        drvCheck("t3_lite_pixels", hsLite, 256);
        drvCheck("t3_accepted_768", accCount, 768);

        // CNN ready toggling every cycle during the drain
        applyReset();
        sendTile(17, 7, lcyc);
        decide(1'b1, dcyc);
        n = 0;
        while (hsCnn < TILE_PIX && n < 2000) begin
            iCnnReady = cyc[0];
            tick();
            n++;
        end
        iCnnReady = 1'b1;
        repeat (3) tick();
        drvCheck("t4_cnn_pixels", hsCnn, 256);
        drvCheck("t4_tiles_done", tilesDone, 1);

        // Decision overflow with no tiles
        applyReset();
        decide(1'b1, dcyc);
        drvCheck("t5_err_after_1", oDecErr, 0);
        decide(1'b0, dcyc);
        drvCheck("t5_err_after_2", oDecErr, 0);
        decide(1'b1, dcyc);
        drvCheck("t5_err_after_3", oDecErr, 1);
        repeat (10) tick();
        drvCheck("t5_err_sticky", oDecErr, 1);

        // Reset in the middle of a drain
        applyReset();
        sendTile(50, 1, lcyc);
        decide(1'b1, dcyc);
        n = 0;
        while (hsCnn < 100 && n < 1000) begin
            tick();
            n++;
        end
        iRst = 1'b0;
        #1;
        drvCheck("t6_cnn_valid_in_reset", oCnnValid, 0);
        drvCheck("t6_lite_valid_in_reset", oLiteValid, 0);
        drvCheck("t6_ready_in_reset", oReady, 1);
        tick();
        tick();
        iRst = 1'b1;
        tick();
        sendTile(7, 1, lcyc);
        decide(1'b0, dcyc);
        waitHs(TILE_PIX, 1000);
        drvCheck("t6_first_pixel_after_reset", riseData, 7);
        drvCheck("t6_no_cnn_after_reset", hsCnn, 0);

        // Randomized traffic, decisions and backpressure
        applyReset();
        for (int i = 0; i < 8000; i++) begin
            iValid         = ($urandom_range(0, 3) != 0);
            iData          = 8'($urandom);
            iDecisionValid = ($urandom_range(0, 249) == 0);
            iRouteToCnn    = 1'($urandom);
            iCnnReady      = ($urandom_range(0, 3) != 0);
            iLiteReady     = ($urandom_range(0, 3) != 0);
            tick();
        end
        iValid = 1'b0; iDecisionValid = 1'b0; iCnnReady = 1'b1; iLiteReady = 1'b1;
        n = 0;
        while (tileCnt != 0 && n < 4000) begin
            iDecisionValid = (tileCnt > decQ.size()) && (decQ.size() < 2);
            iRouteToCnn    = 1'($urandom);
            tick();
            n++;
        end
        iDecisionValid = 1'b0;
        repeat (3) tick();
        drvCheck("rand_all_tiles_drained", tileCnt, 0);
        drvCheck("rand_tiles_done", tilesDone, tilesFilled);
        drvCheck("rand_pixels_out", hsCnn + hsLite, TILE_PIX * tilesFilled);
        drvCheck("rand_enough_tiles", tilesFilled > 5, 1);

        $display("Result: errors=%0d of %0d checks", drvErrors + monErrors, drvChecks + monChecks);
        $finish;
    end

endmodule
